// File: rtl/conv_window_sequencer.sv
// Walks the output map of one conv layer slice, streams K*K taps per window into mac_volume, emits results via valid/ready.
// Optional build macro CONV_SEQ_PERF_CNT_EN adds the stall_cycles output-stall counter.
module conv_window_sequencer #(
   parameter int IMG_W   = 16,
   parameter int IMG_H   = 16,
   parameter int K       = 3,
   parameter int STRIDE  = 1,
   parameter int ADDR_W  = 10,
   parameter int MAC_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              pix_rd_en,
   output logic [7:0]        ker_addr,
   output logic              ker_rd_en,
   output logic              mac_start,
   input  logic [15:0]       conv_in,
   output logic [15:0]       out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   input  logic              out_ready
`ifdef CONV_SEQ_PERF_CNT_EN
   ,output logic [31:0]      stall_cycles
`endif
);

   localparam int OW = (IMG_W - K) / STRIDE + 1;
   localparam int OH = (IMG_H - K) / STRIDE + 1;
   localparam logic [ADDR_W-1:0] L_IMG_W  = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] L_K      = ADDR_W'(K);
   localparam logic [ADDR_W-1:0] L_STRIDE = ADDR_W'(STRIDE);
   localparam logic [ADDR_W-1:0] L_OW     = ADDR_W'(OW);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_EMIT} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_row, r_col, r_ky, r_kx;
   logic [7:0]        r_drain;
   logic              r_mac_start;
   logic              r_done;
   logic [15:0]       r_out_data;
   logic [ADDR_W-1:0] r_out_addr;

   logic              w_last_tap, w_last_win, w_drain_end, w_hs;
   logic [ADDR_W-1:0] w_pix_lin, w_ker_lin, w_out_lin;

   assign w_last_tap  = (r_ky == ADDR_W'(K - 1)) && (r_kx == ADDR_W'(K - 1));
   assign w_last_win  = (r_row == ADDR_W'(OH - 1)) && (r_col == ADDR_W'(OW - 1));
   assign w_drain_end = (r_drain == 8'(MAC_LAT));
   assign w_hs        = (r_state == S_EMIT) && out_ready;
   assign w_pix_lin   = (r_row * L_STRIDE + r_ky) * L_IMG_W + r_col * L_STRIDE + r_kx;
   assign w_ker_lin   = r_ky * L_K + r_kx;
   assign w_out_lin   = r_row * L_OW + r_col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      busy      = (r_state != S_IDLE);
      pix_rd_en = 1'b0;
      ker_rd_en = 1'b0;
      pix_addr  = '0;
      ker_addr  = '0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: if (go) w_next = S_LOAD;
         S_LOAD: begin
            pix_rd_en = 1'b1;
            ker_rd_en = 1'b1;
            pix_addr  = w_pix_lin;
            ker_addr  = 8'(w_ker_lin);
            if (w_last_tap) w_next = S_DRAIN;
         end
         S_DRAIN: if (w_drain_end) w_next = S_EMIT;
         S_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = w_last_win ? S_IDLE : S_LOAD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row       <= '0;
         r_col       <= '0;
         r_ky        <= '0;
         r_kx        <= '0;
         r_drain     <= '0;
         r_mac_start <= 1'b0;
         r_done      <= 1'b0;
         r_out_data  <= '0;
         r_out_addr  <= '0;
      end else begin
         // mac_start lags rd_en by the buffer read latency
         r_mac_start <= pix_rd_en;
         r_done      <= w_hs && w_last_win;
         case (r_state)
            S_IDLE: if (go) begin
               r_row <= '0;
               r_col <= '0;
               r_ky  <= '0;
               r_kx  <= '0;
            end
            S_LOAD: begin
               r_drain <= '0;
               if (r_kx == ADDR_W'(K - 1)) begin
                  r_kx <= '0;
                  r_ky <= (r_ky == ADDR_W'(K - 1)) ? '0 : r_ky + 1'b1;
               end else begin
                  r_kx <= r_kx + 1'b1;
               end
            end
            S_DRAIN: begin
               r_drain <= r_drain + 1'b1;
               if (w_drain_end) begin
                  r_out_data <= conv_in;
                  r_out_addr <= w_out_lin;
               end
            end
            S_EMIT: if (out_ready && !w_last_win) begin
               if (r_col == ADDR_W'(OW - 1)) begin
                  r_col <= '0;
                  r_row <= r_row + 1'b1;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mac_start = r_mac_start;
   assign done      = r_done;
   assign out_data  = r_out_data;
   assign out_addr  = r_out_addr;

`ifdef CONV_SEQ_PERF_CNT_EN
   logic [31:0] r_stall;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_stall <= '0;
      else if (r_state == S_IDLE && go)       r_stall <= '0;
      else if (r_state == S_EMIT && !out_ready && r_stall != 32'hFFFF_FFFF)
                                              r_stall <= r_stall + 1'b1;
   end
   assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer on a 4x4 image with a 3x3 kernel (2x2 outputs).
module tb_conv_window_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        go = 1'b0;
   logic        busy, done, pix_rd_en, ker_rd_en, mac_start, out_valid;
   logic        out_ready = 1'b1;
   logic [9:0]  pix_addr, out_addr;
   logic [7:0]  ker_addr;
   logic [15:0] conv_in = 16'h0;
   logic [15:0] out_data;
`ifdef CONV_SEQ_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   conv_window_sequencer #(
      .IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .ADDR_W(10), .MAC_LAT(1)
   ) dut (
      .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
      .pix_addr(pix_addr), .pix_rd_en(pix_rd_en),
      .ker_addr(ker_addr), .ker_rd_en(ker_rd_en),
      .mac_start(mac_start), .conv_in(conv_in),
      .out_data(out_data), .out_addr(out_addr),
      .out_valid(out_valid), .out_ready(out_ready)
`ifdef CONV_SEQ_PERF_CNT_EN
      ,.stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        go;
      logic        rdy;
      logic [15:0] cin;
      logic        busy;
      logic        rd;
      logic [9:0]  pa;
      logic [7:0]  ka;
      logic        mac;
      logic        vld;
      logic [15:0] od;
      logic [9:0]  oa;
   } vec_t;

   vec_t tbl[14];
   int   pa_exp[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

   int   hs_q[$];
   int   done_cnt, done_cyc, last_hs_cyc;
   logic busy_at_done;
   bit   timed_out;

   task automatic pulse_go();
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
   endtask

   // Steps cycles from posedge+1, logging handshakes and done, then a 30-cycle tail after done.
   task automatic run_to_done(input int go_until, input int go_pulse);
      int cyc = 0;
      int tail = -1;
      hs_q.delete();
      done_cnt = 0;
      timed_out = 1'b1;
      while (cyc < 300 && tail != 0) begin
         go = (cyc < go_until) || (cyc == go_pulse);
         @(negedge clk);
         if (out_valid && out_ready) begin
            hs_q.push_back(int'(out_addr));
            last_hs_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               done_cyc = cyc;
               busy_at_done = busy;
               timed_out = 1'b0;
               tail = 31;
            end
         end
         @(posedge clk); #1;
         cyc++;
         if (tail > 0) tail--;
      end
      go = 1'b0;
   endtask

   task automatic check_run(input string tag, input int first_addr);
      check({tag, "_timeout"}, 32'(timed_out), 32'd0);
      check({tag, "_num_out"}, 32'(hs_q.size()), 32'(4 - first_addr));
      for (int i = 0; i < hs_q.size() && i < 4 - first_addr; i++)
         check({tag, "_out_addr"}, 32'(hs_q[i]), 32'(first_addr + i));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_done_lag"}, 32'(done_cyc - last_hs_cyc), 32'd1);
      check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] held_data;
      logic [9:0]  held_addr;
      int          n;

      for (int i = 0; i < 14; i++) begin
         tbl[i] = '{go: (i == 0), rdy: 1'b1, cin: 16'h0, busy: (i != 0), rd: 1'b0,
                    pa: 10'd0, ka: 8'd0, mac: 1'b0, vld: 1'b0, od: 16'h0, oa: 10'd0};
         if (i >= 1 && i <= 9) begin
            tbl[i].rd = 1'b1;
            tbl[i].pa = 10'(pa_exp[i - 1]);
            tbl[i].ka = 8'(i - 1);
         end
         if (i >= 2 && i <= 10) tbl[i].mac = 1'b1;
      end
      tbl[11].cin = 16'h1234;
      tbl[12].cin = 16'hFFFF;
      tbl[12].vld = 1'b1;
      tbl[12].od  = 16'h1234;
      tbl[13].rd  = 1'b1;
      tbl[13].pa  = 10'd1;
      tbl[13].od  = 16'h1234;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pix_rd_en", 32'(pix_rd_en), 32'd0);
      check("rst_ker_rd_en", 32'(ker_rd_en), 32'd0);
      check("rst_mac_start", 32'(mac_start), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_pix_addr", 32'(pix_addr), 32'd0);
      check("rst_ker_addr", 32'(ker_addr), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_addr", 32'(out_addr), 32'd0);
`ifdef CONV_SEQ_PERF_CNT_EN
      check("rst_stall_cycles", stall_cycles, 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // window 0 cycle by cycle, go at cycle 0
      for (int i = 0; i < 14; i++) begin
         go        = tbl[i].go;
         out_ready = tbl[i].rdy;
         conv_in   = tbl[i].cin;
         @(negedge clk);
         check($sformatf("c%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
         check($sformatf("c%0d_pix_rd_en", i), 32'(pix_rd_en), 32'(tbl[i].rd));
         check($sformatf("c%0d_ker_rd_en", i), 32'(ker_rd_en), 32'(tbl[i].rd));
         check($sformatf("c%0d_pix_addr", i), 32'(pix_addr), 32'(tbl[i].pa));
         check($sformatf("c%0d_ker_addr", i), 32'(ker_addr), 32'(tbl[i].ka));
         check($sformatf("c%0d_mac_start", i), 32'(mac_start), 32'(tbl[i].mac));
         check($sformatf("c%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].vld));
         check($sformatf("c%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
         check($sformatf("c%0d_out_addr", i), 32'(out_addr), 32'(tbl[i].oa));
         check($sformatf("c%0d_done", i), 32'(done), 32'd0);
         @(posedge clk); #1;
      end
      go = 1'b0;
      conv_in = 16'h0;
      run_to_done(0, -1);
      check_run("run1", 1);

      // backpressure in the first EMIT
      out_ready = 1'b0;
      conv_in = 16'h00AB;
      pulse_go();
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_valid_seen", 32'(out_valid), 32'd1);
      held_data = out_data;
      held_addr = out_addr;
      check("bp_captured_data", 32'(held_data), 32'h00AB);
      check("bp_captured_addr", 32'(held_addr), 32'd0);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         conv_in = 16'hFFFF;
         check($sformatf("bp%0d_valid", s), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d_data", s), 32'(out_data), 32'(held_data));
         check($sformatf("bp%0d_addr", s), 32'(out_addr), 32'(held_addr));
         check($sformatf("bp%0d_no_load", s), 32'(pix_rd_en), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      run_to_done(0, -1);
      check_run("bp_run", 0);
`ifdef CONV_SEQ_PERF_CNT_EN
      check("bp_stall_cycles", stall_cycles, 32'd5);
`endif

      // reset in the middle of window 2 LOAD
      pulse_go();
      repeat (28) begin
         @(posedge clk); #1;
      end
      check("mid_pix_rd_en", 32'(pix_rd_en), 32'd1);
      check("mid_pix_addr", 32'(pix_addr), 32'd9);
      check("mid_ker_addr", 32'(ker_addr), 32'd4);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      check("mrst_pix_rd_en", 32'(pix_rd_en), 32'd0);
      check("mrst_mac_start", 32'(mac_start), 32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_pix_addr", 32'(pix_addr), 32'd0);
      check("mrst_out_data", 32'(out_data), 32'd0);
      check("mrst_out_addr", 32'(out_addr), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      run_to_done(1, -1);
      check_run("after_rst", 0);

      // go held through half the run plus a stray pulse later on
      run_to_done(30, 40);
      check_run("go_ignored", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
Controller that sequences one mac_volume datapath across a full convolution layer slice. It walks the output feature map, issues K*K pixel and kernel reads per window, and holds mac_start for exactly the tap count. It captures the ReLU'd 16-bit result and hands it downstream with a valid/ready handshake. Sits between the on-chip pixel/kernel buffers and the layer's output writer.

Parameters:
IMG_W, 16, input feature-map width in pixels
IMG_H, 16, input feature-map height in pixels
K, 3, square kernel size (taps per window = K*K)
STRIDE, 1, window step in both directions
ADDR_W, 10, pixel buffer address width (IMG_W*IMG_H <= 2**ADDR_W)
MAC_LAT, 1, cycles from last tap data presented to valid conv_in

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
go  in  1  start one layer pass; sampled only in IDLE
busy  out  1  high from the cycle after go is accepted until the cycle done pulses
done  out  1  one-cycle pulse after the final output handshake
pix_addr  out  ADDR_W  pixel buffer read address
pix_rd_en  out  1  pixel buffer read enable (1-cycle read latency)
ker_addr  out  8  kernel buffer read address (ky*K+kx)
ker_rd_en  out  1  kernel buffer read enable (1-cycle read latency), equal to pix_rd_en
mac_start  out  1  to mac_volume start: high = accumulate, low = clear
conv_in  in  16  conv_out_relued from mac_volume
out_data  out  16  captured window result
out_addr  out  ADDR_W  linear output index row*OW+col
out_valid  out  1  out_data/out_addr valid
out_ready  in  1  downstream accept

Behaviour:
- OW=(IMG_W-K)/STRIDE+1, OH=(IMG_H-K)/STRIDE+1 (integer division); row/col counters cover 0..OH-1 and 0..OW-1; ky/kx tap counters cover 0..K-1, kx fastest.
- Reset: state IDLE, all counters 0; busy, done, pix_rd_en, ker_rd_en, mac_start and out_valid are 0; pix_addr, ker_addr, out_data and out_addr are 0.
- States: IDLE -> LOAD -> DRAIN -> EMIT -> (LOAD | IDLE).
- IDLE: go=1 -> LOAD, row=col=0. go is ignored in every other state.
- LOAD: lasts exactly K*K cycles. pix_rd_en=ker_rd_en=1. pix_addr=(row*STRIDE+ky)*IMG_W+col*STRIDE+kx. ker_addr=ky*K+kx. Tap counters advance every cycle.
- mac_start is pix_rd_en registered once, to align with the 1-cycle buffer data. It is therefore high for exactly K*K consecutive cycles per window.
- DRAIN: lasts 1+MAC_LAT cycles with rd_en low. On the last DRAIN edge conv_in is registered into out_data, and out_addr=row*OW+col. Then EMIT.
- EMIT: out_valid=1. out_data and out_addr are held stable while out_ready=0. mac_start is low throughout, which guarantees at least one clear cycle between windows.
- EMIT handshake, out_valid&out_ready:
  - if this is the last window (row=OH-1 and col=OW-1): done=1 next cycle, busy drops the same cycle, go to IDLE.
  - otherwise col++, or col=0 and row++ at OW-1, then LOAD.
- Window throughput with out_ready tied high: K*K+2+MAC_LAT cycles (12 for defaults).
- With go accepted at cycle 0 and defaults, out_valid first rises at cycle 12.
- Reset asserted mid-operation: immediate return to the reset values. No partial output is emitted and no done pulse is generated.
- out_ready while out_valid=0 has no effect.
- conv_in is sampled only on the capture edge and is don't-care otherwise.

Optional Feature:
CONV_SEQ_PERF_CNT_EN:
- Defined: adds output stall_cycles, 32 bits. It resets to 0 and counts cycles with out_valid=1 and out_ready=0. It saturates at 0xFFFFFFFF, clears when go is accepted, and holds after done.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- IMG_W=IMG_H=4, K=3, STRIDE=1, out_ready=1, go at cycle 0 -> 4 outputs with out_addr 0,1,2,3; first out_valid at cycle 12; done one cycle after the 4th handshake; busy low afterwards.
- Same config, window 0 -> pix_addr sequence 0,1,2,4,5,6,8,9,10 and ker_addr 0..8; mac_start high exactly 9 cycles, starting 1 cycle after pix_rd_en.
- Backpressure: out_ready=0 for 5 cycles in the first EMIT -> out_data/out_addr stable and no new LOAD; with the macro defined, stall_cycles=5.
- conv_in driven 0x1234 on capture edge -> out_data=0x1234; conv_in changed to 0xFFFF during EMIT -> out_data unchanged.
- Reset pulsed in the middle of LOAD of window 2 -> all outputs 0 next edge; a new go restarts at out_addr 0.
- go held high during busy, and a second go pulse mid-run -> ignored: exactly 4 outputs and a single done pulse.
